// File: rtl/traffic_pkg.sv
// Shared definitions for intersection signal controllers: phase codes,
// direction constants and the phase-to-lamp decode.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } phase_e;

  localparam logic NS = 1'b0;
  localparam logic EW = 1'b1;

  typedef struct packed {
    logic ns_g;
    logic ns_y;
    logic ns_r;
    logic ew_g;
    logic ew_y;
    logic ew_r;
    logic walk;
  } lamps_t;

  // Illegal codes fall back to both heads red so a corrupt state never shows green.
  function automatic lamps_t lamp_decode(input phase_e p);
    lamps_t l;
    l = '{ns_r: 1'b1, ew_r: 1'b1, default: 1'b0};
    case (p)
      NS_GREEN:  begin l.ns_g = 1'b1; l.ns_r = 1'b0; end
      NS_YELLOW: begin l.ns_y = 1'b1; l.ns_r = 1'b0; end
      EW_GREEN:  begin l.ew_g = 1'b1; l.ew_r = 1'b0; end
      EW_YELLOW: begin l.ew_y = 1'b1; l.ew_r = 1'b0; end
      PED_WALK:  l.walk = 1'b1;
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase length counter: synchronous clear, saturating increment and a
// compare-against-target expiry flag.
module phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic [CW-1:0] i_sat,
  input  logic [CW-1:0] i_match,
  output logic [CW-1:0] o_cnt,
  output logic          o_expired
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != i_sat) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_expired = (r_cnt == i_match);

endmodule

// File: rtl/traffic_phase_controller.sv
// Actuated two-way intersection controller: vehicle-actuated greens,
// fixed yellow/all-red clearance and an on-demand pedestrian walk.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW    = 2,
  parameter int ALLRED    = 1,
  parameter int WALK      = 3,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic       nsgreen,
  output logic       nsyellow,
  output logic       nsred,
  output logic       ewgreen,
  output logic       ewyellow,
  output logic       ewred,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CW-1:0] GMIN_M1   = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_M1   = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YELLOW_M1 = CW'(YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_M1 = CW'(ALLRED - 1);
  localparam logic [CW-1:0] WALK_M1   = CW'(WALK - 1);

  phase_e        r_state;
  logic          r_dir;
  logic          r_ped_pending;
  lamps_t        r_lamps;

  phase_e        w_next_state;
  phase_e        w_dir_green;
  logic          w_next_dir;
  logic          w_next_pending;
  logic          w_enter_walk;
  logic          w_clr;
  logic          w_min_done;
  logic          w_ns_exit;
  logic          w_ew_exit;
  logic          w_expired;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_sat;
  logic [CW-1:0] w_match;

  // Per-state timer target; greens also saturate there so a resting green never wraps.
  always_comb begin
    w_match = '1;
    w_sat   = '1;
    case (r_state)
      ALL_RED:              w_match = ALLRED_M1;
      NS_GREEN, EW_GREEN:   begin w_match = GMAX_M1; w_sat = GMAX_M1; end
      NS_YELLOW, EW_YELLOW: w_match = YELLOW_M1;
      PED_WALK:             w_match = WALK_M1;
      default:              ;
    endcase
  end

  phase_timer #(.CW(CW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_sat     (w_sat),
    .i_match   (w_match),
    .o_cnt     (w_cnt),
    .o_expired (w_expired)
  );

  assign w_dir_green = (r_dir == EW) ? EW_GREEN : NS_GREEN;
  assign w_min_done  = (w_cnt >= GMIN_M1);
  // In green the expiry target is GREEN_MAX-1, i.e. the max-out point.
  assign w_ns_exit   = w_min_done && (ew_car || r_ped_pending) && (!ns_car || w_expired);
  assign w_ew_exit   = w_min_done && (ns_car || r_ped_pending) && (!ew_car || w_expired);

  always_comb begin
    w_next_state = r_state;
    w_next_dir   = r_dir;
    case (r_state)
      ALL_RED:
        if (w_expired) w_next_state = (r_ped_pending || ped_req) ? PED_WALK : w_dir_green;
      NS_GREEN:
        if (w_ns_exit) w_next_state = NS_YELLOW;
      EW_GREEN:
        if (w_ew_exit) w_next_state = EW_YELLOW;
      NS_YELLOW:
        if (w_expired) begin
          w_next_state = ALL_RED;
          w_next_dir   = EW;
        end
      EW_YELLOW:
        if (w_expired) begin
          w_next_state = ALL_RED;
          w_next_dir   = NS;
        end
      PED_WALK:
        if (w_expired) w_next_state = w_dir_green;
      default:
        w_next_state = ALL_RED;
    endcase
  end

  assign w_clr          = (w_next_state != r_state);
  assign w_enter_walk   = (w_next_state == PED_WALK) && (r_state != PED_WALK);
  assign w_next_pending = (r_ped_pending || (ped_req && r_state != PED_WALK)) && !w_enter_walk;

  // Lamps are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ALL_RED;
      r_dir         <= NS;
      r_ped_pending <= 1'b0;
      r_lamps       <= lamp_decode(ALL_RED);
    end else begin
      r_state       <= w_next_state;
      r_dir         <= w_next_dir;
      r_ped_pending <= w_next_pending;
      r_lamps       <= lamp_decode(w_next_state);
    end
  end

  assign nsgreen  = r_lamps.ns_g;
  assign nsyellow = r_lamps.ns_y;
  assign nsred    = r_lamps.ns_r;
  assign ewgreen  = r_lamps.ew_g;
  assign ewyellow = r_lamps.ew_y;
  assign ewred    = r_lamps.ew_r;
  assign walk     = r_lamps.walk;
  assign phase    = r_state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: a vector table for the
// short scenarios plus looped checks for the long rest and saturation runs.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       rst, ns_car, ew_car, ped_req;
  logic       nsgreen, nsyellow, nsred, ewgreen, ewyellow, ewred, walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_controller dut (
    .clk      (clk),
    .rst      (rst),
    .ns_car   (ns_car),
    .ew_car   (ew_car),
    .ped_req  (ped_req),
    .nsgreen  (nsgreen),
    .nsyellow (nsyellow),
    .nsred    (nsred),
    .ewgreen  (ewgreen),
    .ewyellow (ewyellow),
    .ewred    (ewred),
    .walk     (walk),
    .phase    (phase)
  );

  typedef struct {
    logic       rst;
    logic       ns;
    logic       ew;
    logic       ped;
    logic [2:0] exp_phase;
  } vec_t;

  vec_t vecs[$];

  // Lamp pattern {nsg,nsy,nsr,ewg,ewy,ewr,walk} required for each phase code.
  function automatic logic [6:0] exp_lamps(input logic [2:0] p);
    case (p)
      3'd0:    return 7'b0010010;
      3'd1:    return 7'b1000010;
      3'd2:    return 7'b0100010;
      3'd3:    return 7'b0011000;
      3'd4:    return 7'b0010100;
      3'd5:    return 7'b0010011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic void add(input logic r, input logic n, input logic e,
                              input logic p, input logic [2:0] ph, input int reps);
    for (int k = 0; k < reps; k++) vecs.push_back('{r, n, e, p, ph});
  endfunction

  // Drive one cycle of inputs, clock it, then compare just after the edge.
  task automatic step(input string name, input int idx, input logic r, input logic n,
                      input logic e, input logic p, input logic [2:0] ph);
    logic [6:0] lamps;
    rst = r; ns_car = n; ew_car = e; ped_req = p;
    @(posedge clk);
    #1;
    lamps = {nsgreen, nsyellow, nsred, ewgreen, ewyellow, ewred, walk};
    checks++;
    if (phase !== ph) begin
      errors++;
      $display("FAIL %s[%0d] phase: got %0d expected %0d", name, idx, phase, ph);
    end
    checks++;
    if (lamps !== exp_lamps(ph)) begin
      errors++;
      $display("FAIL %s[%0d] lamps: got %b expected %b", name, idx, lamps, exp_lamps(ph));
    end
    $display("%s[%0d] rst=%b ns=%b ew=%b ped=%b phase=%0d lamps=%b", name, idx, r, n, e, p,
             phase, lamps);
  endtask

  initial begin
    rst = 1'b1; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;

    // EW demand only: NS min green, clearance, then EW rests.
    add(1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 1, 4);
    add(0, 0, 1, 0, 2, 2);
    add(0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 3, 6);
    // One-cycle ped pulse in NS green, walk, then EW rests with nothing pending.
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 2, 2);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 5, 3);
    add(0, 0, 0, 0, 3, 6);
    // ped_req held across the walk and dropped on its last cycle: no second walk.
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 5, 3);
    add(0, 0, 0, 0, 1, 9);
    // Reset in cycle 1 of NS yellow with a walk pending clears the request.
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 2, 1);
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 7);
    // Reset in mid-walk.
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 5, 1);
    add(0, 0, 0, 0, 5, 1);
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 3);

    for (int i = 0; i < vecs.size(); i++)
      step("vec", i, vecs[i].rst, vecs[i].ns, vecs[i].ew, vecs[i].ped, vecs[i].exp_phase);

    // No demand at all: NS green rests for 50 cycles.
    step("idle", 0, 1, 0, 0, 0, 3'd0);
    for (int i = 1; i <= 50; i++) step("idle", i, 0, 0, 0, 0, 3'd1);

    // Continuous demand on both approaches: 30-cycle period, 12-cycle greens.
    step("both", 0, 1, 1, 1, 0, 3'd0);
    for (int i = 1; i <= 70; i++) begin
      int t;
      logic [2:0] ph;
      t = (i - 1) % 30;
      if (t < 12)       ph = 3'd1;
      else if (t < 14)  ph = 3'd2;
      else if (t == 14) ph = 3'd0;
      else if (t < 27)  ph = 3'd3;
      else if (t < 29)  ph = 3'd4;
      else              ph = 3'd0;
      step("both", i, 0, 1, 1, 0, ph);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
